// File: rtl/uart_rx_fifo.sv
// UART receiver (8E1, 16x oversampling) feeding a first-word-fall-through byte FIFO.
// Only frames with good parity and stop bit are queued; a full FIFO drops them and flags overrun.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       Rx_RD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_EMPTY,
  output logic       Rx_FULL,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR,
  output logic       Rx_OVERRUN
);

  function automatic int unsigned div_for(input int unsigned baud);
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  localparam int unsigned Div0 = div_for(300);
  localparam int unsigned Div1 = div_for(1200);
  localparam int unsigned Div2 = div_for(4800);
  localparam int unsigned Div3 = div_for(9600);
  localparam int unsigned Div4 = div_for(19200);
  localparam int unsigned Div5 = div_for(38400);
  localparam int unsigned Div6 = div_for(57600);
  localparam int unsigned Div7 = div_for(115200);
  localparam int unsigned DivW = $clog2(Div0 + 1);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] CntFull = (AddrW + 1)'(DEPTH);
  localparam logic [AddrW:0] CntOne  = (AddrW + 1)'(1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic             rx_meta, rx_sync;
  logic [2:0]       baud_q;
  logic [DivW-1:0]  div_cnt, div_max;
  logic             tick, mid, start_det;
  logic [2:0]       state;
  logic [3:0]       phase;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_bit, stop_bit, done;
  logic             frame_ferr, frame_perr, good, push, pop;
  logic [7:0]       mem [DEPTH];
  logic [AddrW-1:0] wr_ptr, rd_ptr;
  logic [AddrW:0]   count;
  logic             ferr, perr, ovr;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    div_max = '0;
    case (baud_select)
      3'd0: div_max = DivW'(Div0 - 1);
      3'd1: div_max = DivW'(Div1 - 1);
      3'd2: div_max = DivW'(Div2 - 1);
      3'd3: div_max = DivW'(Div3 - 1);
      3'd4: div_max = DivW'(Div4 - 1);
      3'd5: div_max = DivW'(Div5 - 1);
      3'd6: div_max = DivW'(Div6 - 1);
      3'd7: div_max = DivW'(Div7 - 1);
    endcase
  end

  assign start_det = (state == StIdle) && Rx_EN && !rx_sync;
  assign tick      = (div_cnt == div_max);
  assign mid       = tick && (phase == 4'd7);

  // The divider also restarts on start detection so mid-bit samples align to the falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      baud_q  <= '0;
    end else begin
      baud_q <= baud_select;
      if ((baud_select != baud_q) || start_det || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= StIdle;
      phase    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == StIdle) begin
        if (start_det) begin
          state   <= StStart;
          phase   <= '0;
          bit_idx <= '0;
        end
      end else if (!Rx_EN) begin
        state <= StIdle;
      end else begin
        if (tick) begin
          phase <= phase + 4'd1;
        end
        if (mid) begin
          case (state)
            StStart: state <= rx_sync ? StIdle : StData;
            StData: begin
              shift   <= {rx_sync, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= StParity;
              end
            end
            StParity: begin
              par_bit <= rx_sync;
              state   <= StStop;
            end
            StStop: begin
              stop_bit <= rx_sync;
              done     <= 1'b1;
              state    <= StIdle;
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

  assign frame_ferr = !stop_bit;
  assign frame_perr = ^{shift, par_bit};
  assign good       = done && !frame_ferr && !frame_perr;
  assign pop        = Rx_RD && (count != '0);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push       = good && ((count != CntFull) || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ferr <= 1'b0;
      perr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (done) begin
        ferr <= frame_ferr;
        perr <= frame_perr;
      end
      if (pop) begin
        ovr <= 1'b0;
      end else if (good && !push) begin
        ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AddrW'(1);
      end
      if (push && !pop) begin
        count <= count + CntOne;
      end else if (pop && !push) begin
        count <= count - CntOne;
      end
    end
  end

  assign Rx_DATA    = (count == '0) ? 8'h00 : mem[rd_ptr];
  assign Rx_EMPTY   = (count == '0);
  assign Rx_FULL    = (count == CntFull);
  assign Rx_FERROR  = ferr;
  assign Rx_PERROR  = perr;
  assign Rx_OVERRUN = ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 50 MHz / 115200 baud: a queue-based model is compared every cycle,
// with literal expectations at key points of the directed frame sequence.
module tb_uart_rx_fifo;

  localparam int Depth = 4;
  localparam int Bit   = 16 * 27;
  // Falling edge at iteration 0: 2 sync flops + 1 detect cycle, 8 ticks to mid start bit,
  // 10 bit periods to the stop sample, registered one clock later.
  localparam int PushAt  = 3 + 8 * 27 + 10 * Bit + 1;
  localparam int AbortAt = 5 * Bit + Bit / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN, RxD, Rx_RD;
  logic [7:0] Rx_DATA;
  logic       Rx_EMPTY, Rx_FULL, Rx_FERROR, Rx_PERROR, Rx_OVERRUN;

  uart_rx_fifo #(
    .CLK_HZ(50000000),
    .DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .RxD        (RxD),
    .Rx_RD      (Rx_RD),
    .Rx_DATA    (Rx_DATA),
    .Rx_EMPTY   (Rx_EMPTY),
    .Rx_FULL    (Rx_FULL),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_OVERRUN (Rx_OVERRUN)
  );

  always #10 clk = ~clk;

  logic [7:0] q[$];
  logic       m_ferr, m_perr, m_ovr, m_pushed;
  logic       check_en;
  int         errors, checks;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ferr   = 1'b0;
    m_perr   = 1'b0;
    m_ovr    = 1'b0;
    m_pushed = 1'b0;
  endfunction

  function automatic void model_read();
    if (q.size() > 0) begin
      void'(q.pop_front());
      m_ovr = 1'b0;
    end
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop,
                                      input logic rd);
    if (rd) model_read();
    m_ferr = !stop;
    m_perr = (^d) ^ par;
    if (!m_ferr && !m_perr) begin
      if (q.size() < Depth) begin
        q.push_back(d);
        m_pushed = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk1("empty", Rx_EMPTY, q.size() == 0);
      chk1("full", Rx_FULL, q.size() == Depth);
      chk1("ferror", Rx_FERROR, m_ferr);
      chk1("perror", Rx_PERROR, m_perr);
      chk1("overrun", Rx_OVERRUN, m_ovr);
      if (q.size() != 0) chk8("data", Rx_DATA, q[0]);
      else if (!m_pushed) chk8("data_reset", Rx_DATA, 8'h00);
    end
  end

  // abort_kind: 0 = full frame, 1 = Rx_EN dropped at data bit 4, 2 = reset at data bit 4.
  task automatic send(input logic [7:0] d, input logic par, input logic stop,
                      input int abort_kind, input logic rd_on_push);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    @(posedge clk); #1;
    for (int c = 0; c < 11 * Bit; c++) begin
      if (abort_kind == 0 || c < AbortAt) RxD = bits[c / Bit];
      else RxD = 1'b1;
      if (abort_kind == 1 && c == AbortAt) Rx_EN = 1'b0;
      if (abort_kind == 2 && c == AbortAt) begin
        reset    = 1'b0;
        check_en = 1'b0;
        model_reset();
      end
      if (abort_kind == 2 && c == AbortAt + 10) begin
        reset    = 1'b1;
        check_en = 1'b1;
      end
      if (abort_kind != 0 && c == AbortAt + 600) begin
        Rx_EN = 1'b1;
        break;
      end
      if (rd_on_push && c == PushAt - 1) Rx_RD = 1'b1;
      if (c == PushAt) begin
        Rx_RD = 1'b0;
        if (abort_kind == 0) model_frame(d, par, stop, rd_on_push);
      end
      @(posedge clk); #1;
    end
    RxD = 1'b1;
  endtask

  task automatic read(input string name, input logic [7:0] exp);
    @(posedge clk); #1;
    chk8(name, Rx_DATA, exp);
    Rx_RD = 1'b1;
    @(posedge clk); #1;
    Rx_RD = 1'b0;
    model_read();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    check_en    = 1'b0;
    reset       = 1'b0;
    Rx_EN       = 1'b1;
    RxD         = 1'b1;
    Rx_RD       = 1'b0;
    baud_select = 3'd7;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk1("rst_empty", Rx_EMPTY, 1'b1);
    chk1("rst_full", Rx_FULL, 1'b0);
    chk8("rst_data", Rx_DATA, 8'h00);
    chk1("rst_ferr", Rx_FERROR, 1'b0);
    chk1("rst_perr", Rx_PERROR, 1'b0);
    chk1("rst_ovr", Rx_OVERRUN, 1'b0);
    reset    = 1'b1;
    check_en = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h55, 1'b0, 1'b1, 0, 1'b0);
    chk8("f55_data", Rx_DATA, 8'h55);
    chk1("f55_empty", Rx_EMPTY, 1'b0);
    chk1("f55_perr", Rx_PERROR, 1'b0);

    send(8'hA7, 1'b0, 1'b1, 0, 1'b0);
    chk1("a7bad_perr", Rx_PERROR, 1'b1);
    chk8("a7bad_head", Rx_DATA, 8'h55);

    send(8'h99, 1'b0, 1'b1, 1, 1'b0);
    chk1("en_abort_perr", Rx_PERROR, 1'b1);
    chk8("en_abort_head", Rx_DATA, 8'h55);

    send(8'hA7, 1'b1, 1'b1, 0, 1'b0);
    chk1("a7good_perr", Rx_PERROR, 1'b0);
    send(8'h66, 1'b0, 1'b1, 0, 1'b0);
    send(8'h77, 1'b0, 1'b1, 0, 1'b0);
    chk1("fill_full", Rx_FULL, 1'b1);

    send(8'h88, 1'b0, 1'b1, 0, 1'b1);
    chk1("pushpop_full", Rx_FULL, 1'b1);
    chk8("pushpop_head", Rx_DATA, 8'hA7);
    chk1("pushpop_ovr", Rx_OVERRUN, 1'b0);

    send(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk1("f3c_ferr", Rx_FERROR, 1'b1);
    chk1("f3c_ovr", Rx_OVERRUN, 1'b0);

    @(posedge clk); #1;
    RxD = 1'b0;
    repeat (5 * 27) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    chk1("glitch_ferr", Rx_FERROR, 1'b1);
    chk8("glitch_head", Rx_DATA, 8'hA7);

    send(8'h99, 1'b0, 1'b1, 2, 1'b0);
    chk1("rst_abort_empty", Rx_EMPTY, 1'b1);
    chk1("rst_abort_ferr", Rx_FERROR, 1'b0);

    send(8'h81, 1'b0, 1'b1, 0, 1'b0);
    chk8("f81_data", Rx_DATA, 8'h81);
    read("rd_81", 8'h81);

    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send(b, ^b, 1'b1, 0, 1'b0);
      if (i == 4) chk1("four_full", Rx_FULL, 1'b1);
    end
    chk1("five_ovr", Rx_OVERRUN, 1'b1);
    read("rd_01", 8'h01);
    chk1("rd_ovr_clr", Rx_OVERRUN, 1'b0);
    read("rd_02", 8'h02);
    read("rd_03", 8'h03);
    read("rd_04", 8'h04);
    @(posedge clk); #1;
    chk1("drain_empty", Rx_EMPTY, 1'b1);
    read("rd_when_empty", Rx_DATA);
    repeat (5) @(posedge clk);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
